// File: rtl/x_stages_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : x_stages_mul_arbiter
// Brief    : Round-robin arbiter that shares one external pipelined unsigned
//            multiplier between NUM_REQ requesters. It tracks the owner tag of
//            every product in flight and drives a single tagged result bus.
//            Result backpressure freezes the multiplier through its ce input.
// Revision : 1.0 - initial release
// ============================================================================
module x_stages_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 1,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      mul_ce,
    output logic [DATA_W-1:0]         mul_din0,
    output logic [DATA_W-1:0]         mul_din1,
    input  logic [2*DATA_W-1:0]       mul_dout,
    output logic                      res_valid,
    output logic [ID_W-1:0]           res_id,
    output logic [2*DATA_W-1:0]       res_data,
    input  logic                      res_ready,
    output logic                      idle
);

    // Valid/tag shadow of the multiplier stages; index MUL_LAT-1 is the output.
    logic [MUL_LAT-1:0] r_vld;
    logic [ID_W-1:0]    r_id [MUL_LAT];
    // Index of the most recently granted requester.
    logic [ID_W-1:0]    r_ptr;

    logic               w_advance;
    logic               w_run;
    logic               w_found;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [NUM_REQ-1:0] w_grant;

    // The pipeline only stalls when a valid result sits unconsumed at the output;
    // reset forces the multiplier frozen and blocks every grant.
    assign w_advance = ~(r_vld[MUL_LAT-1] & ~res_ready);
    assign w_run     = w_advance & reset;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        w_found   = 1'b0;
        w_idx     = '0;
        w_gnt_idx = '0;
        w_grant   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
        if (w_run && w_found) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    // Steer the granted requester's operands to the multiplier, zero otherwise.
    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                mul_din0 = req_a[i*DATA_W +: DATA_W];
                mul_din1 = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Shift the valid/tag shadow in lockstep with the multiplier's ce.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vld <= '0;
            r_ptr <= ID_W'(NUM_REQ - 1);
            for (int k = 0; k < MUL_LAT; k++) begin
                r_id[k] <= '0;
            end
        end else if (w_advance) begin
            r_vld[0] <= |w_grant;
            r_id[0]  <= w_gnt_idx;
            for (int k = 1; k < MUL_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_id[k]  <= r_id[k-1];
            end
            if (|w_grant) begin
                r_ptr <= w_gnt_idx;
            end
        end
    end

    assign req_ready = w_grant;
    assign mul_ce    = w_run;
    // Stale stage contents are hidden while reset is asserted.
    assign res_valid = r_vld[MUL_LAT-1] & reset;
    assign res_id    = r_id[MUL_LAT-1];
    assign res_data  = mul_dout;
    assign idle      = ~(|r_vld) | ~reset;

endmodule
`default_nettype wire

// File: tb/tb_x_stages_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_x_stages_mul_arbiter
// Brief    : Bench for x_stages_mul_arbiter. Two harnesses (MUL_LAT = 1 and 3)
//            each drive directed and random traffic into their own instance
//            and an external pipelined multiplier. A reference model predicts
//            grants, ce, operands, result validity and idle; expected results
//            are queued at grant time and popped by a separate result monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_x_stages_mul_arbiter;

    localparam int C_N  = 4;
    localparam int C_DW = 32;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] p;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit done [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_h
        localparam int LAT = (g == 0) ? 1 : 3;

        logic                  rst_n     = 1'b0;
        logic [C_N-1:0]        req_valid = '0;
        logic [C_N*C_DW-1:0]   req_a     = '0;
        logic [C_N*C_DW-1:0]   req_b     = '0;
        logic                  res_ready = 1'b1;
        logic [C_N-1:0]        req_ready;
        logic                  mul_ce;
        logic [C_DW-1:0]       din0;
        logic [C_DW-1:0]       din1;
        logic [2*C_DW-1:0]     mul_dout;
        logic                  res_valid;
        logic [1:0]            res_id;
        logic [2*C_DW-1:0]     res_data;
        logic                  idle;

        x_stages_mul_arbiter #(
            .NUM_REQ(C_N), .DATA_W(C_DW), .MUL_LAT(LAT), .ID_W(2)
        ) dut (
            .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_a(req_a),
            .req_b(req_b), .req_ready(req_ready), .mul_ce(mul_ce),
            .mul_din0(din0), .mul_din1(din1), .mul_dout(mul_dout),
            .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
            .res_ready(res_ready), .idle(idle)
        );

        // External ce-gated multiplier with LAT register stages.
        logic [63:0] pipe [LAT];
        always @(posedge clk) begin
            if (mul_ce) begin
                pipe[0] <= {32'b0, din0} * {32'b0, din1};
                for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
            end
        end
        assign mul_dout = pipe[LAT-1];

        // Reference model: in-flight entries carry the number of advancing
        // edges still needed before they reach the result bus.
        exp_t        sb[$];
        int          rem[$];
        int          m_ptr = C_N - 1;
        int          m_gi;
        bit          m_outv;
        bit          m_stall;
        logic [3:0]  m_rdy;
        logic [31:0] m_a;
        logic [31:0] m_b;
        exp_t        m_e;

        // Predict handshake-level outputs and queue expected results on grant.
        always @(negedge clk) begin
            if (!rst_n) begin
                check($sformatf("L%0d_rst_req_ready", LAT), 64'(req_ready), 64'd0);
                check($sformatf("L%0d_rst_mul_ce", LAT), 64'(mul_ce), 64'd0);
                check($sformatf("L%0d_rst_din", LAT), {din0, din1}, 64'd0);
                check($sformatf("L%0d_rst_res_valid", LAT), 64'(res_valid), 64'd0);
                check($sformatf("L%0d_rst_idle", LAT), 64'(idle), 64'd1);
                sb.delete();
                rem.delete();
                m_ptr = C_N - 1;
            end else begin
                m_outv  = (rem.size() > 0) && (rem[0] == 0);
                m_stall = m_outv && !res_ready;
                m_gi    = -1;
                if (!m_stall) begin
                    for (int k = 1; k <= C_N; k++) begin
                        if (m_gi < 0 && req_valid[(m_ptr + k) % C_N]) m_gi = (m_ptr + k) % C_N;
                    end
                end
                m_rdy = 4'b0;
                m_a   = 32'd0;
                m_b   = 32'd0;
                if (m_gi >= 0) begin
                    m_rdy[m_gi] = 1'b1;
                    m_a = req_a[m_gi*C_DW +: C_DW];
                    m_b = req_b[m_gi*C_DW +: C_DW];
                end
                check($sformatf("L%0d_req_ready", LAT), 64'(req_ready), 64'(m_rdy));
                check($sformatf("L%0d_mul_ce", LAT), 64'(mul_ce), 64'(!m_stall));
                check($sformatf("L%0d_din0", LAT), 64'(din0), 64'(m_a));
                check($sformatf("L%0d_din1", LAT), 64'(din1), 64'(m_b));
                check($sformatf("L%0d_res_valid", LAT), 64'(res_valid), 64'(m_outv));
                check($sformatf("L%0d_idle", LAT), 64'(idle), 64'(rem.size() == 0));
                if (!m_stall) begin
                    if (m_outv) void'(rem.pop_front());
                    foreach (rem[i]) rem[i] = rem[i] - 1;
                    if (m_gi >= 0) begin
                        rem.push_back(LAT - 1);
                        m_e.id = 2'(m_gi);
                        m_e.p  = 64'(m_a) * 64'(m_b);
                        sb.push_back(m_e);
                        m_ptr = m_gi;
                    end
                end
            end
        end

        // Result monitor: whatever the bus shows must match the oldest expectation.
        always @(negedge clk) begin
            if (rst_n && res_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check($sformatf("L%0d_res_extra", LAT), 64'd1, 64'd0);
                end else begin
                    check($sformatf("L%0d_res_id", LAT), 64'(res_id), 64'(sb[0].id));
                    check($sformatf("L%0d_res_data", LAT), res_data, sb[0].p);
                    if (res_ready) void'(sb.pop_front());
                end
            end
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
            req_a[i*C_DW +: C_DW] = a;
            req_b[i*C_DW +: C_DW] = b;
        endtask

        task automatic rand_ops();
            for (int i = 0; i < C_N; i++) begin
                if ($urandom_range(0, 7) == 0) set_op(i, 32'hFFFF_FFFF, $urandom);
                else set_op(i, $urandom, $urandom);
            end
        endtask

        task automatic do_reset();
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
        endtask

        initial begin
            repeat (3) step();
            rst_n = 1'b1;
            step();
            // Single request from requester 2.
            set_op(2, 32'hC000_0000, 32'd2);
            req_valid = 4'b0100;
            step();
            req_valid = '0;
            repeat (LAT + 2) step();
            // Maximum operands from requester 0.
            set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            req_valid = 4'b0001;
            step();
            req_valid = '0;
            repeat (LAT + 2) step();
            // Fairness: everyone requests for 8 cycles after reset.
            do_reset();
            req_valid = 4'hF;
            for (int c = 0; c < 8; c++) begin
                rand_ops();
                step();
            end
            req_valid = '0;
            repeat (LAT + 2) step();
            // Backpressure with requesters 1 and 3 streaming.
            req_valid = 4'b1010;
            for (int c = 0; c < 10; c++) begin
                rand_ops();
                res_ready = !(c >= LAT + 1 && c < LAT + 4);
                step();
            end
            res_ready = 1'b1;
            req_valid = '0;
            repeat (LAT + 3) step();
            // Reset while a product is in flight, then all requesters request.
            rand_ops();
            req_valid = 4'b0010;
            step();
            req_valid = '0;
            do_reset();
            req_valid = 4'hF;
            rand_ops();
            step();
            req_valid = '0;
            repeat (LAT + 2) step();
            // Single requester streaming five operand pairs.
            req_valid = 4'b0100;
            for (int c = 0; c < 5; c++) begin
                set_op(2, $urandom, $urandom);
                step();
            end
            req_valid = '0;
            repeat (LAT + 2) step();
            // Random traffic with random backpressure and occasional resets.
            for (int c = 0; c < 400; c++) begin
                rand_ops();
                req_valid = 4'($urandom);
                res_ready = ($urandom_range(0, 3) != 0);
                rst_n     = ($urandom_range(0, 99) != 0);
                step();
            end
            // Drain.
            rst_n     = 1'b1;
            res_ready = 1'b1;
            req_valid = '0;
            repeat (LAT + 3) step();
            check($sformatf("L%0d_drain_pending", LAT), 64'(sb.size()), 64'd0);
            check($sformatf("L%0d_drain_idle", LAT), 64'(idle), 64'd1);
            done[g] = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk);
            if (done[0] && done[1]) break;
        end
        if (!(done[0] && done[1])) begin
            checks++;
            failures++;
            $display("FAIL timeout actual=not_done required=done");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
